// File: rtl/wash_phase_timer.sv
// Phase-duration timer for the washing-machine controller: loads a per-phase
// cycle budget on each timed-phase entry, counts it down and reports expiry.
module wash_phase_timer #(
  parameter int SOAK_CYCLES       = 8,
  parameter int WASH_CYCLES       = 16,
  parameter int RINSE_CYCLES      = 12,
  parameter int SPIN_CYCLES       = 10,
  parameter int MAX_BALANCE_RETRY = 3,
  parameter int CNT_W             = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       state,
  input  logic             sig_Lid_Closed,
  input  logic             sig_Out_Of_Balance,
  output logic             sig_Time_Out,
  output logic             balance_fault,
  output logic             running,
  output logic [CNT_W-1:0] remaining
);

  localparam int RETRY_W = (MAX_BALANCE_RETRY < 1) ? 1 : $clog2(MAX_BALANCE_RETRY + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SOAK  = 3'd1;
  localparam logic [2:0] ST_WASH  = 3'd2;
  localparam logic [2:0] ST_RINSE = 3'd3;
  localparam logic [2:0] ST_SPIN  = 3'd4;

  // Counter holds "cycles left minus one", so a budget of 2^CNT_W still fits.
  localparam logic [CNT_W-1:0] SOAK_LOAD  = CNT_W'(SOAK_CYCLES - 1);
  localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RINSE_LOAD = CNT_W'(RINSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_BALANCE_RETRY);

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_HOLD,
    T_DONE
  } tstate_t;

  tstate_t            tstate;
  logic [2:0]         phase_q;
  logic [RETRY_W-1:0] retry_cnt;

  logic               timed;
  logic               phase_change;
  logic [CNT_W-1:0]   phase_load;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    timed        = (state >= ST_SOAK) && (state <= ST_SPIN);
    phase_change = (state != phase_q);
    phase_load   = '0;
    case (state)
      ST_SOAK:  phase_load = SOAK_LOAD;
      ST_WASH:  phase_load = WASH_LOAD;
      ST_RINSE: phase_load = RINSE_LOAD;
      ST_SPIN:  phase_load = SPIN_LOAD;
      default:  phase_load = '0;
    endcase
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // branch below reads the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tstate        <= T_IDLE;
      phase_q       <= ST_IDLE;
      retry_cnt     <= '0;
      sig_Time_Out  <= 1'b0;
      balance_fault <= 1'b0;
      running       <= 1'b0;
      remaining     <= '0;
    end else begin
      phase_q      <= state;
      sig_Time_Out <= 1'b0;

      if (phase_change && timed) begin
        tstate    <= T_RUN;
        running   <= 1'b1;
        remaining <= phase_load;
        if (state != ST_SPIN) retry_cnt <= '0;
      end else if (!timed) begin
        tstate    <= T_IDLE;
        running   <= 1'b0;
        remaining <= '0;
        if (phase_change && state == ST_IDLE) begin
          balance_fault <= 1'b0;
          retry_cnt     <= '0;
        end
      end else if (tstate == T_RUN || tstate == T_HOLD) begin
        if (state == ST_SPIN && sig_Out_Of_Balance) begin
          if (retry_cnt < RETRY_MAX) begin
            tstate    <= T_RUN;
            remaining <= SPIN_LOAD;
            retry_cnt <= retry_cnt + 1'b1;
          end else begin
            tstate        <= T_DONE;
            running       <= 1'b0;
            balance_fault <= 1'b1;
          end
        end else if (!sig_Lid_Closed) begin
          tstate <= T_HOLD;
        end else if (remaining != '0) begin
          // The closing edge itself counts, so each open cycle costs one cycle.
          tstate    <= T_RUN;
          remaining <= remaining - 1'b1;
        end else begin
          tstate       <= T_DONE;
          running      <= 1'b0;
          sig_Time_Out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Phase-duration timer for the washing-machine controller. Watches the controller's `state` bus, loads a per-phase cycle budget on every entry to a timed phase, and counts it down. It freezes while the lid is open and restarts the spin budget on an out-of-balance event. It returns a one-cycle `sig_Time_Out` pulse to the controller and raises a sticky `balance_fault` when spin retries are exhausted.

## Interface
- `SOAK_CYCLES`, default 8: SOAK duration in clock cycles.
- `WASH_CYCLES`, default 16: WASH duration in clock cycles.
- `RINSE_CYCLES`, default 12: RINSE duration in clock cycles.
- `SPIN_CYCLES`, default 10: SPIN duration in clock cycles.
- `MAX_BALANCE_RETRY`, default 3: number of spin restarts allowed before fault.
- `CNT_W`, default 8: width of the down-counter. Every *_CYCLES value must be in 1..2^CNT_W. 0 is illegal.
- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `state`, in, 3: controller state. Timed phases are 1=SOAK, 2=WASH, 3=RINSE, 4=SPIN. Codes 0, 5, 6, 7 are untimed.
- `sig_Lid_Closed`, in, 1: 1 = lid closed. Counting is permitted only while this is 1.
- `sig_Out_Of_Balance`, in, 1: drum imbalance. Acted on only in SPIN.
- `sig_Time_Out`, out, 1: one-cycle pulse when the current phase budget expires.
- `balance_fault`, out, 1: sticky flag; retries exhausted in SPIN.
- `running`, out, 1: 1 while a phase budget is loaded and not yet expired.
- `remaining`, out, CNT_W: current counter value (cycles left minus 1).

## Operation
- Internal FSM states:
  - T_IDLE: untimed state.
  - T_RUN: counting.
  - T_HOLD: lid open, counter frozen.
  - T_DONE: expired; waiting for a phase change.
- `phase_q` holds the registered copy of `state`. A phase entry is detected when `state != phase_q` and `state` is in 1..4.
- On phase entry: `remaining` <= PHASE_CYCLES-1 and FSM goes to T_RUN. If the new phase is not SPIN, `retry_cnt` clears.
- Entering an untimed state from anywhere goes to T_IDLE with `remaining` = 0. Entering state 0 also clears `balance_fault` and `retry_cnt`.
- T_RUN behaviour:
  - With lid closed and `remaining` > 0: decrement `remaining`.
  - With lid closed and `remaining` == 0: assert `sig_Time_Out` for one cycle and go to T_DONE.
- T_RUN or T_HOLD with lid open: go to or stay in T_HOLD. The count is frozen and no time-out is issued. When the lid closes, return to T_RUN; counting resumes the next edge.
- Out-of-balance in SPIN (during T_RUN or T_HOLD):
  - If `retry_cnt` < MAX_BALANCE_RETRY: reload SPIN_CYCLES-1, increment `retry_cnt`, stay in T_RUN.
  - Otherwise: set `balance_fault`, go to T_DONE with no `sig_Time_Out`.
- T_DONE: no further pulses until a phase change. Re-entering the same code after an untimed state counts as a new entry.
- Priority for simultaneous events, highest first:
  1. phase change
  2. out-of-balance (SPIN only)
  3. lid open
  4. count or expire
- Expiry is blocked if the lid opens on the same cycle.
- `running` = 1 in T_RUN and T_HOLD, 0 otherwise.

## Timing
- Reset values: `sig_Time_Out`=0, `balance_fault`=0, `running`=0, `remaining`=0, `phase_q`=0, `retry_cnt`=0, FSM in T_IDLE.
- All outputs are registered. There are no combinational input-to-output paths.
- Latency: with `state` changing before edge E0 to a phase of N cycles and the lid closed throughout:
  - After E0: `remaining`=N-1 and `running`=1.
  - After edge E(N): `sig_Time_Out`=1 and `running`=0.
  - After E(N+1): `sig_Time_Out`=0.
  - For N=1 the pulse follows E1.
- Each lid-open cycle delays expiry by exactly one cycle.
- A phase change mid-count takes effect at the next edge. The old count is discarded.
- Reset asserted mid-phase: outputs return to reset values immediately (asynchronously). After release, the current `state` is treated as a fresh entry at the first edge.
- `remaining` never underflows or wraps.

## Test plan
- Reset release with `state`=0, then `state`=2 (WASH, 16) with lid closed → `running` is 1 for 16 cycles, `sig_Time_Out` pulses once after the 16th edge, then T_DONE with no further pulses.
- `state`=1 (SOAK, 8), lid opened for 5 cycles at `remaining`=4 → `remaining` holds at 4 and the pulse arrives 13 edges after entry.
- `state`=4 (SPIN, 10), out-of-balance asserted for one cycle at `remaining`=3 → `remaining` reloads to 9 and the pulse comes 10 edges later.
- SPIN with 4 out-of-balance events → the first 3 reload; the 4th sets `balance_fault`, `running`=0, and no pulse is issued. The fault persists through states 5 and 3 and clears on `state`=0.
- `state` 3→2 when `remaining`=5 → after the next edge `remaining`=15 and no pulse for RINSE. In the same test, a lid open coinciding with `remaining`=0 gives no pulse until the lid closes.
- `reset_n` pulsed low mid-WASH → all outputs are 0 immediately; after release with `state`=2 held, `remaining`=15 at the first edge.
